// File: rtl/divider_arbiter_if.sv
// Request/response and divider-side signal bundle for divider_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface divider_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid_in;
    logic [N_REQ*WIDTH-1:0] req_dividend_in;
    logic [N_REQ*WIDTH-1:0] req_divisor_in;
    logic [N_REQ-1:0]       req_ready_out;
    logic [N_REQ-1:0]       resp_valid_out;
    logic [WIDTH-1:0]       resp_quotient_out;
    logic [WIDTH-1:0]       resp_remainder_out;
    logic                   resp_error_out;
    logic [WIDTH-1:0]       div_dividend_out;
    logic [WIDTH-1:0]       div_divisor_out;
    logic                   div_valid_out;
    logic [WIDTH-1:0]       div_quotient_in;
    logic [WIDTH-1:0]       div_remainder_in;
    logic                   div_valid_in;
    logic                   div_error_in;

    modport slave (
        input  req_valid_in, req_dividend_in, req_divisor_in,
        input  div_quotient_in, div_remainder_in, div_valid_in, div_error_in,
        output req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
        output resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
    );

    modport master (
        output req_valid_in, req_dividend_in, req_divisor_in,
        output div_quotient_in, div_remainder_in, div_valid_in, div_error_in,
        input  req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
        input  resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ requesters, one division in flight.
// Define DIV_TIMEOUT_EN to add a WAIT-state watchdog that answers with an error after TIMEOUT_CYCLES.
module divider_arbiter #(
    parameter int N_REQ          = 3,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    divider_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               err_q, err_d;

    logic               winnerValid;
    logic [IDX_W-1:0]   winnerIdx;
    logic [WIDTH-1:0]   winnerDividend;
    logic [WIDTH-1:0]   winnerDivisor;
    logic [N_REQ-1:0]   readyComb;
    logic [N_REQ-1:0]   respValid;

`ifdef DIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    function automatic logic [IDX_W-1:0] wrapIdx(input int base, input int offset);
        return IDX_W'((base + offset) % N_REQ);
    endfunction

    // Search starts just after the last served requester, so the one just served ranks lowest.
    always_comb begin
        winnerValid = 1'b0;
        winnerIdx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!winnerValid && bus.req_valid_in[wrapIdx(int'(rr_q), i)]) begin
                winnerValid = 1'b1;
                winnerIdx   = wrapIdx(int'(rr_q), i);
            end
        end
    end

    assign winnerDividend = bus.req_dividend_in[winnerIdx*WIDTH +: WIDTH];
    assign winnerDivisor  = bus.req_divisor_in[winnerIdx*WIDTH +: WIDTH];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        err_d      = err_q;
        readyComb  = '0;
        respValid  = '0;
`ifdef DIV_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (winnerValid) begin
                    readyComb[winnerIdx] = 1'b1;
                    grant_d    = winnerIdx;
                    dividend_d = winnerDividend;
                    divisor_d  = winnerDivisor;
                    // A zero divisor is answered locally; the divider is never started.
                    if (winnerDivisor == '0) begin
                        quot_d  = '1;
                        rem_d   = winnerDividend;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.div_valid_in) begin
                    quot_d  = bus.div_quotient_in;
                    rem_d   = bus.div_remainder_in;
                    err_d   = bus.div_error_in;
                    state_d = RESPOND;
                end
`ifdef DIV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESPOND: begin
                respValid[grant_q] = 1'b1;
                rr_d    = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            rr_q       <= IDX_W'(N_REQ - 1);
            grant_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
`ifdef DIV_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Ready is masked by reset so no accept strobe leaks out while reset is asserted.
    assign bus.req_ready_out      = readyComb & {N_REQ{rst_n_in}};
    assign bus.resp_valid_out     = respValid;
    assign bus.resp_quotient_out  = quot_q;
    assign bus.resp_remainder_out = rem_q;
    assign bus.resp_error_out     = err_q & (state_q == RESPOND);
    assign bus.div_dividend_out   = dividend_q;
    assign bus.div_divisor_out    = divisor_q;
    assign bus.div_valid_out      = (state_q == ISSUE);
endmodule

// File: tb/tb_divider_arbiter.sv
// Directed self-checking bench for divider_arbiter; the divider is played by hand-driven stimulus.
module tb_divider_arbiter;
    localparam int N_REQ = 3;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rstN;
    int   numCompared   = 0;
    int   numMismatched = 0;

    divider_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    divider_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(64)) dut (
        .clk_in   (clk),
        .rst_n_in (rstN),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.req_valid_in     = '0;
        bus.req_dividend_in  = '0;
        bus.req_divisor_in   = '0;
        bus.div_quotient_in  = '0;
        bus.div_remainder_in = '0;
        bus.div_valid_in     = 1'b0;
        bus.div_error_in     = 1'b0;
    endtask

    task automatic setReq(input int idx, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
        bus.req_dividend_in[idx*WIDTH +: WIDTH] = dvd;
        bus.req_divisor_in[idx*WIDTH +: WIDTH]  = dvs;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearInputs();
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Divider stub answer: one cycle pulse on div_valid_in.
    task automatic divAnswer(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic e);
        bus.div_valid_in     = 1'b1;
        bus.div_quotient_in  = q;
        bus.div_remainder_in = r;
        bus.div_error_in     = e;
        tick();
        bus.div_valid_in     = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        clearInputs();
        bus.req_valid_in = 3'b111;
        setReq(0, 32'd9, 32'd3);
        #1;
        numCompared++; if (bus.req_ready_out !== 3'b000) begin numMismatched++; $display("[TB] FAIL reset_ready: got %b expected 000", bus.req_ready_out); end
        numCompared++; if (bus.resp_valid_out !== 3'b000) begin numMismatched++; $display("[TB] FAIL reset_resp_valid: got %b expected 000", bus.resp_valid_out); end
        numCompared++; if (bus.div_valid_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_div_valid: got %b expected 0", bus.div_valid_out); end
        numCompared++; if (bus.resp_quotient_out !== 32'd0 || bus.resp_remainder_out !== 32'd0 || bus.resp_error_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_result: got q=%h r=%h e=%b expected all 0", bus.resp_quotient_out, bus.resp_remainder_out, bus.resp_error_out); end
        numCompared++; if (bus.div_dividend_out !== 32'd0 || bus.div_divisor_out !== 32'd0) begin numMismatched++; $display("[TB] FAIL reset_div_operands: got %h/%h expected 0/0", bus.div_dividend_out, bus.div_divisor_out); end
        doReset();
    endtask

    task automatic test_single();
        setReq(0, 32'd100, 32'd2);
        bus.req_valid_in = 3'b001;
        #1;
        numCompared++; if (bus.req_ready_out !== 3'b001) begin numMismatched++; $display("[TB] FAIL single_ready: got %b expected 001", bus.req_ready_out); end
        tick();
        bus.req_valid_in = 3'b000;
        #1;
        numCompared++; if (bus.div_valid_out !== 1'b1) begin numMismatched++; $display("[TB] FAIL single_div_valid: got %b expected 1", bus.div_valid_out); end
        numCompared++; if (bus.div_dividend_out !== 32'd100 || bus.div_divisor_out !== 32'd2) begin numMismatched++; $display("[TB] FAIL single_div_operands: got %0d/%0d expected 100/2", bus.div_dividend_out, bus.div_divisor_out); end
        tick();
        numCompared++; if (bus.div_valid_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL single_div_pulse: got %b expected 0", bus.div_valid_out); end
        divAnswer(32'd50, 32'd0, 1'b0);
        numCompared++; if (bus.resp_valid_out !== 3'b001) begin numMismatched++; $display("[TB] FAIL single_resp_valid: got %b expected 001", bus.resp_valid_out); end
        numCompared++; if (bus.resp_quotient_out !== 32'd50 || bus.resp_remainder_out !== 32'd0 || bus.resp_error_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL single_result: got q=%0d r=%0d e=%b expected 50 0 0", bus.resp_quotient_out, bus.resp_remainder_out, bus.resp_error_out); end
        tick();
        numCompared++; if (bus.resp_valid_out !== 3'b000 || bus.resp_quotient_out !== 32'd50) begin numMismatched++; $display("[TB] FAIL single_hold: got v=%b q=%0d expected 000 50", bus.resp_valid_out, bus.resp_quotient_out); end
    endtask

    task automatic test_round_robin();
        int expGrant [4] = '{0, 1, 2, 0};
        logic [WIDTH-1:0] expQ [3] = '{32'd50, 32'd12, 32'd100};
        logic [WIDTH-1:0] expR [3] = '{32'd0, 32'd6, 32'd0};
        logic [N_REQ-1:0] oneHot;
        doReset();
        setReq(0, 32'd100, 32'd2);
        setReq(1, 32'd90, 32'd7);
        setReq(2, 32'd1000, 32'd10);
        bus.req_valid_in = 3'b111;
        #1;
        for (int t = 0; t < 4; t++) begin
            oneHot = '0;
            oneHot[expGrant[t]] = 1'b1;
            numCompared++; if (bus.req_ready_out !== oneHot) begin numMismatched++; $display("[TB] FAIL rr_ready_%0d: got %b expected %b", t, bus.req_ready_out, oneHot); end
            tick();
            numCompared++; if (bus.req_ready_out !== 3'b000 || bus.div_valid_out !== 1'b1) begin numMismatched++; $display("[TB] FAIL rr_issue_%0d: got ready=%b dv=%b expected 000 1", t, bus.req_ready_out, bus.div_valid_out); end
            tick();
            tick();
            divAnswer(expQ[expGrant[t]], expR[expGrant[t]], 1'b0);
            numCompared++; if (bus.resp_valid_out !== oneHot || bus.resp_quotient_out !== expQ[expGrant[t]] || bus.resp_remainder_out !== expR[expGrant[t]]) begin numMismatched++; $display("[TB] FAIL rr_resp_%0d: got v=%b q=%0d r=%0d expected %b %0d %0d", t, bus.resp_valid_out, bus.resp_quotient_out, bus.resp_remainder_out, oneHot, expQ[expGrant[t]], expR[expGrant[t]]); end
            numCompared++; if (bus.req_ready_out !== 3'b000) begin numMismatched++; $display("[TB] FAIL rr_respond_ready_%0d: got %b expected 000", t, bus.req_ready_out); end
            tick();
        end
        bus.req_valid_in = 3'b000;
    endtask

    task automatic test_zero_divisor();
        setReq(1, 32'd7, 32'd0);
        bus.req_valid_in = 3'b010;
        #1;
        numCompared++; if (bus.req_ready_out !== 3'b010) begin numMismatched++; $display("[TB] FAIL zero_ready: got %b expected 010", bus.req_ready_out); end
        tick();
        bus.req_valid_in = 3'b000;
        #1;
        numCompared++; if (bus.div_valid_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL zero_no_div: got %b expected 0", bus.div_valid_out); end
        numCompared++; if (bus.resp_valid_out !== 3'b010) begin numMismatched++; $display("[TB] FAIL zero_resp_valid: got %b expected 010", bus.resp_valid_out); end
        numCompared++; if (bus.resp_quotient_out !== 32'hFFFF_FFFF || bus.resp_remainder_out !== 32'd7 || bus.resp_error_out !== 1'b1) begin numMismatched++; $display("[TB] FAIL zero_result: got q=%h r=%0d e=%b expected ffffffff 7 1", bus.resp_quotient_out, bus.resp_remainder_out, bus.resp_error_out); end
        tick();
        numCompared++; if (bus.resp_valid_out !== 3'b000 || bus.div_valid_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL zero_after: got v=%b dv=%b expected 000 0", bus.resp_valid_out, bus.div_valid_out); end
    endtask

    task automatic test_spurious();
        bus.div_quotient_in  = 32'h123;
        bus.div_remainder_in = 32'h45;
        bus.div_error_in     = 1'b1;
        bus.div_valid_in     = 1'b1;
        tick();
        bus.div_valid_in     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            numCompared++; if (bus.resp_valid_out !== 3'b000 || bus.resp_error_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL spurious_resp_%0d: got v=%b e=%b expected 000 0", k, bus.resp_valid_out, bus.resp_error_out); end
            numCompared++; if (bus.resp_quotient_out !== 32'hFFFF_FFFF || bus.resp_remainder_out !== 32'd7) begin numMismatched++; $display("[TB] FAIL spurious_hold_%0d: got q=%h r=%0d expected ffffffff 7", k, bus.resp_quotient_out, bus.resp_remainder_out); end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        setReq(2, 32'd40, 32'd5);
        bus.req_valid_in = 3'b100;
        #1;
        numCompared++; if (bus.req_ready_out !== 3'b100) begin numMismatched++; $display("[TB] FAIL midrst_ready: got %b expected 100", bus.req_ready_out); end
        tick();
        bus.req_valid_in = 3'b000;
        tick();
        #2;
        rstN = 1'b0;
        #1;
        numCompared++; if (bus.resp_valid_out !== 3'b000 || bus.div_valid_out !== 1'b0 || bus.resp_error_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL midrst_strobes: got v=%b dv=%b e=%b expected 000 0 0", bus.resp_valid_out, bus.div_valid_out, bus.resp_error_out); end
        numCompared++; if (bus.resp_quotient_out !== 32'd0 || bus.resp_remainder_out !== 32'd0 || bus.div_dividend_out !== 32'd0 || bus.div_divisor_out !== 32'd0) begin numMismatched++; $display("[TB] FAIL midrst_buses: got q=%h r=%h dd=%h ds=%h expected all 0", bus.resp_quotient_out, bus.resp_remainder_out, bus.div_dividend_out, bus.div_divisor_out); end
        tick();
        rstN = 1'b1;
        tick();
        divAnswer(32'd8, 32'd0, 1'b0);
        numCompared++; if (bus.resp_valid_out !== 3'b000) begin numMismatched++; $display("[TB] FAIL midrst_stale: got %b expected 000", bus.resp_valid_out); end
        setReq(0, 32'd8, 32'd3);
        bus.req_valid_in = 3'b001;
        #1;
        numCompared++; if (bus.req_ready_out !== 3'b001) begin numMismatched++; $display("[TB] FAIL midrst_next_ready: got %b expected 001", bus.req_ready_out); end
        tick();
        bus.req_valid_in = 3'b000;
        tick();
        divAnswer(32'd2, 32'd2, 1'b0);
        numCompared++; if (bus.resp_valid_out !== 3'b001 || bus.resp_quotient_out !== 32'd2 || bus.resp_remainder_out !== 32'd2) begin numMismatched++; $display("[TB] FAIL midrst_next_resp: got v=%b q=%0d r=%0d expected 001 2 2", bus.resp_valid_out, bus.resp_quotient_out, bus.resp_remainder_out); end
        tick();
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout();
        setReq(0, 32'd5, 32'd1);
        bus.req_valid_in = 3'b001;
        tick();
        bus.req_valid_in = 3'b000;
        tick();
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k < 64) begin
                numCompared++; if (bus.resp_valid_out !== 3'b000) begin numMismatched++; $display("[TB] FAIL timeout_early_%0d: got %b expected 000", k, bus.resp_valid_out); end
            end else begin
                numCompared++; if (bus.resp_valid_out !== 3'b001 || bus.resp_error_out !== 1'b1 || bus.resp_quotient_out !== 32'd0 || bus.resp_remainder_out !== 32'd0) begin numMismatched++; $display("[TB] FAIL timeout_resp: got v=%b e=%b q=%h r=%h expected 001 1 0 0", bus.resp_valid_out, bus.resp_error_out, bus.resp_quotient_out, bus.resp_remainder_out); end
            end
        end
        tick();
        divAnswer(32'd5, 32'd0, 1'b0);
        numCompared++; if (bus.resp_valid_out !== 3'b000 || bus.resp_quotient_out !== 32'd0) begin numMismatched++; $display("[TB] FAIL timeout_late: got v=%b q=%h expected 000 0", bus.resp_valid_out, bus.resp_quotient_out); end
    endtask
`else
    task automatic test_long_wait();
        int earlyResp = 0;
        setReq(1, 32'd21, 32'd4);
        bus.req_valid_in = 3'b010;
        tick();
        bus.req_valid_in = 3'b000;
        tick();
        for (int k = 0; k < 100; k++) begin
            if (bus.resp_valid_out !== 3'b000) earlyResp++;
            tick();
        end
        numCompared++; if (earlyResp !== 0) begin numMismatched++; $display("[TB] FAIL longwait_early: got %0d pulses expected 0", earlyResp); end
        divAnswer(32'd5, 32'd1, 1'b0);
        numCompared++; if (bus.resp_valid_out !== 3'b010 || bus.resp_quotient_out !== 32'd5 || bus.resp_remainder_out !== 32'd1 || bus.resp_error_out !== 1'b0) begin numMismatched++; $display("[TB] FAIL longwait_resp: got v=%b q=%0d r=%0d e=%b expected 010 5 1 0", bus.resp_valid_out, bus.resp_quotient_out, bus.resp_remainder_out, bus.resp_error_out); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_divisor();
        test_spurious();
        test_reset_mid_wait();
`ifdef DIV_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule
